aes128_cipher_core: RTL and testbench



---
 rtl/aes128_cipher_core.sv | 117 +++++++++++
 tb/tb_aes128_cipher_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_cipher_core.sv
// Iterative AES-128 encryption core: one full round per clock. The expanded key
// schedule is latched at acceptance so the upstream key expansion may move on.
module aes128_cipher_core #(
    parameter int NR = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [0:127]              plaintext,
    input  logic [0:128*(NR+1)-1]     fullkey,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [0:127]              ciphertext,
    output logic                      busy
);
    localparam int KW = 128 * (NR + 1);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t           fsm_q, fsm_d;
    logic [127:0]   st_q;
    logic [KW-1:0]  key_q;
    logic [3:0]     rnd_q;
    logic           last;
    logic [7:0]     sb [16];
    logic [7:0]     sr [16];
    logic [7:0]     mc [16];
    logic [127:0]   rk [16];
    logic [127:0]   rk_sel;
    logic [127:0]   round_out;

    assign last = (rnd_q == 4'(NR));

    // State byte k sits at st_q[127-8k -: 8]; k = 4*col + row.
    for (genvar k = 0; k < 16; k++) begin : g_byte
        assign sb[k] = sbox(st_q[127-8*k -: 8]);
        assign sr[k] = sb[4*(((k/4) + (k%4)) % 4) + (k%4)];
        assign round_out[127-8*k -: 8] = (last ? sr[k] : mc[k]) ^ rk_sel[127-8*k -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr[4*c];
        assign a1 = sr[4*c+1];
        assign a2 = sr[4*c+2];
        assign a3 = sr[4*c+3];
        assign mc[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        assign mc[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        assign mc[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        assign mc[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end

    // Round key r occupies the r-th 128-bit slice from the top of key_q.
    for (genvar r = 0; r < 16; r++) begin : g_rk
        if (r <= NR) begin : g_used
            assign rk[r] = key_q[KW-1-128*r -: 128];
        end else begin : g_pad
            assign rk[r] = '0;
        end
    end
    assign rk_sel = rk[rnd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= IDLE;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (in_valid)  fsm_d = ROUND;
            ROUND:   if (last)      fsm_d = DONE;
            DONE:    if (out_ready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= '0;
            key_q <= '0;
            rnd_q <= '0;
        end else if (fsm_q == IDLE && in_valid) begin
            st_q  <= plaintext ^ fullkey[0:127];
            key_q <= fullkey;
            rnd_q <= 4'd1;
        end else if (fsm_q == ROUND) begin
            st_q  <= round_out;
            rnd_q <= rnd_q + 4'd1;
        end
    end

    assign in_ready   = (fsm_q == IDLE);
    assign out_valid  = (fsm_q == DONE);
    assign busy       = (fsm_q != IDLE);
    assign ciphertext = st_q;
endmodule

// File: tb/tb_aes128_cipher_core.sv
// Bench for aes128_cipher_core: FIPS-197 and random vectors against a byte-level
// AES model (S-box derived from GF(2^8) inverses), plus handshake corner cases.
module tb_aes128_cipher_core;
    logic           clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic           in_ready, out_valid, busy;
    logic [0:127]   plaintext = '0;
    logic [0:127]   ciphertext;
    logic [0:1407]  fullkey = '0;

    aes128_cipher_core #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .fullkey(fullkey), .out_valid(out_valid),
        .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [7:0] sbox_m [256];

    typedef struct { logic [127:0] key; logic [127:0] pt; logic [127:0] ct; } vec_t;
    vec_t vecs [6];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b;
            b = 0;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                          ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [0:1407] expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [0:1407] fk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) fk[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return fk;
    endfunction

    // State after `upto` rounds (0 = initial key whitening only).
    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [0:1407] fk, input int upto);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] rk, res;
        int coef [4];
        coef = '{2, 3, 1, 1};
        rk = fk[0:127];
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk[127-8*k -: 8];
        for (int rnd = 1; rnd <= upto; rnd++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox_m[s[k]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        s[4*c+r] = 0;
                        for (int j = 0; j < 4; j++) s[4*c+r] ^= gmul(8'(coef[(j-r+4)%4]), t[4*c+j]);
                    end
            end else begin
                s = t;
            end
            rk = fk[128*rnd +: 128];
            for (int k = 0; k < 16; k++) s[k] ^= rk[127-8*k -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [0:1407] fk,
                             input logic [127:0] exp, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin tick(); n++; end
        chk({tag, " in_ready before accept"}, 128'(in_ready), 128'd1);
        plaintext = pt; fullkey = fk; in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        chk({tag, " busy after accept"}, 128'({in_ready, busy}), 128'b01);
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        chk({tag, " latency"}, 128'(n), 128'd10);
        chk({tag, " ciphertext"}, ciphertext, exp);
        tick();
        chk({tag, " handshake ovalid/iready/busy"}, 128'({out_valid, in_ready, busy}), 128'b010);
    endtask

    logic [127:0] key_b, pt_b, ct_b, key_c, pt_c, ct_c;
    logic [0:1407] fk_b, fk_c;
    logic [127:0] exp_q [4];
    int acc_edge [4];
    int e, nacc, nout, ir_bad, ct_bad, dcnt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        build_sbox();
        key_b = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        pt_b  = 128'h3243f6a8885a308d313198a2e0370734;
        ct_b  = 128'h3925841d02dc09fbdc118597196a0b32;
        key_c = 128'h000102030405060708090a0b0c0d0e0f;
        pt_c  = 128'h00112233445566778899aabbccddeeff;
        ct_c  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        fk_b = expand(key_b);
        fk_c = expand(key_c);
        vecs[0] = '{key_b, pt_b, ct_b};
        vecs[1] = '{key_c, pt_c, ct_c};
        for (int i = 2; i < 6; i++) begin
            vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].ct  = encrypt(vecs[i].pt, expand(vecs[i].key), 10);
        end

        // Reset state
        rst_n = 0;
        repeat (3) tick();
        chk("reset iready/ovalid/busy", 128'({in_ready, out_valid, busy}), 128'b100);
        chk("reset ciphertext", ciphertext, 128'h0);
        rst_n = 1;
        tick();

        // Table vectors
        for (int i = 0; i < 6; i++)
            run_block(vecs[i].pt, expand(vecs[i].key), vecs[i].ct, $sformatf("vec%0d", i));

        // Backpressure, key latch, intermediate states
        plaintext = pt_b; fullkey = fk_b; in_valid = 1; out_ready = 0;
        tick();
        chk("B state after edge 0", ciphertext, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        fullkey = fk_c; plaintext = pt_c;
        tick();
        chk("B state after edge 1", ciphertext, 128'ha49c7ff2689f352b6b5bea43026a5049);
        ir_bad = 0; ct_bad = 0; dcnt = 0;
        for (int i = 0; i < 29; i++) begin
            in_valid = i[0];
            fullkey = ~fullkey;
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (in_ready) ir_bad++;
            if (out_valid) begin
                dcnt++;
                if (ciphertext !== ct_b) ct_bad++;
            end
        end
        chk("backpressure in_ready high cycles", 128'(ir_bad), 128'd0);
        chk("backpressure DONE cycles", 128'(dcnt), 128'd21);
        chk("backpressure unstable ciphertext cycles", 128'(ct_bad), 128'd0);
        chk("backpressure final ciphertext", ciphertext, ct_b);
        in_valid = 0; out_ready = 1;
        tick();
        chk("release ovalid/iready/busy", 128'({out_valid, in_ready, busy}), 128'b010);
        tick();
        chk("no stray accept", 128'({in_ready, busy}), 128'b10);

        // Back-to-back with in_valid and out_ready held high
        in_valid = 1; out_ready = 1;
        nacc = 0; nout = 0; e = 0;
        while (nout < 4 && e < 100) begin
            if (out_valid) begin
                chk($sformatf("b2b ciphertext %0d", nout), ciphertext, exp_q[nout]);
                nout++;
            end
            if (in_ready) begin
                if (nacc < 4) begin
                    plaintext = nacc[0] ? pt_c : pt_b;
                    fullkey   = nacc[0] ? fk_c : fk_b;
                    exp_q[nacc] = nacc[0] ? ct_c : ct_b;
                    acc_edge[nacc] = e;
                    nacc++;
                end else begin
                    in_valid = 0;
                end
            end
            tick();
            e++;
        end
        in_valid = 0;
        chk("b2b outputs seen", 128'(nout), 128'd4);
        for (int n = 1; n < 4; n++)
            chk($sformatf("b2b accept edge %0d", n), 128'(acc_edge[n] - acc_edge[0]), 128'(12 * n));
        tick();

        // Asynchronous reset mid-operation
        plaintext = pt_b; fullkey = fk_b; in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        repeat (5) tick();
        #2 rst_n = 0;
        #1;
        chk("mid reset iready/ovalid/busy", 128'({in_ready, out_valid, busy}), 128'b100);
        chk("mid reset ciphertext", ciphertext, 128'h0);
        tick();
        rst_n = 1;
        tick();
        run_block(pt_c, fk_c, ct_c, "post-reset C1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
